axil_mem_target: RTL and testbench
==================================

AXIL_MEM_TARGET -- requirements
Module: axil_mem_target

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits (multiple of 8).
REQ-002 Parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, write-strobe width.
REQ-004 Parameter DEPTH_LOG2, default 8, log2 of memory depth in words.
REQ-005 Port clk input 1: the single clock; all logic on its rising edge.
REQ-006 Port rst input 1: synchronous, active-high reset.
REQ-007 Ports s_axil_awaddr in ADDR_WIDTH, s_axil_awprot in 3, s_axil_awvalid in 1, s_axil_awready out 1: AW channel.
REQ-008 Ports s_axil_wdata in DATA_WIDTH, s_axil_wstrb in STRB_WIDTH, s_axil_wvalid in 1, s_axil_wready out 1: W channel.
REQ-009 Ports s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1: B channel.
REQ-010 Ports s_axil_araddr in ADDR_WIDTH, s_axil_arprot in 3, s_axil_arvalid in 1, s_axil_arready out 1: AR channel.
REQ-011 Ports s_axil_rdata out DATA_WIDTH, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1: R channel.

Function
REQ-012 Block SHALL act as an AXI-lite slave memory of 2^DEPTH_LOG2 words; awprot/arprot SHALL be ignored.
REQ-013 Word index SHALL be addr[ADDR_LSB +: DEPTH_LOG2], ADDR_LSB = log2(STRB_WIDTH); low ADDR_LSB bits ignored (no unaligned error).
REQ-014 Address with any bit above ADDR_LSB+DEPTH_LOG2-1 set SHALL be out of range: response SLVERR (2'b10), no memory write, rdata all zeros; in-range response OKAY (2'b00).
REQ-015 Write FSM states W_IDLE, W_RESP; read FSM states R_IDLE, R_DATA; the two FSMs SHALL run independently and concurrently.
REQ-016 In W_IDLE, awready = W_IDLE and no AW held; wready = W_IDLE and no W held; AW and W accepted in either order or same cycle, each into its own holding register.
REQ-017 On the first edge at which both AW and W are held, the block SHALL write mem bytes whose wstrb bit is 1 (others unchanged), set bvalid=1 with bresp, and go to W_RESP.
REQ-018 Write latency: last of AW/W handshakes at edge N -> commit and bvalid high after edge N+1; awready/wready low from edge N of each accepted beat until return to W_IDLE.
REQ-019 In W_RESP, bvalid and bresp SHALL hold stable until bvalid&&bready; on that edge bvalid falls, holding registers clear, FSM returns to W_IDLE.
REQ-020 arready SHALL equal (state == R_IDLE); on AR handshake at edge N the block SHALL register rdata/rresp from memory and raise rvalid after edge N (1-cycle latency), entering R_DATA.
REQ-021 In R_DATA, rvalid/rdata/rresp SHALL hold stable until rvalid&&rready, then return to R_IDLE (arready high next cycle); max throughput one read per 2 cycles.
REQ-022 Read and write commit to the same word on the same edge SHALL return the old data (read-before-write).
REQ-023 wstrb = 0 on an in-range write SHALL leave memory unchanged and still return OKAY.
REQ-024 No valid/ready output SHALL depend combinationally on any input.

Reset
REQ-025 While rst=1: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0; FSMs to W_IDLE/R_IDLE; holding registers cleared.
REQ-026 Memory contents SHALL NOT be reset; reset mid-transaction SHALL drop held beats and pending responses without writing memory.
REQ-027 awready, wready, arready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Package axil_pkg SHALL hold RESP_OKAY/RESP_SLVERR constants and the write/read FSM state enums.
REQ-029 Storage SHALL be one sub-module be_ram (single write port with byte enables, one registered read port, no reset).

Verification
REQ-030 AW 0x0010 and W 0xDEADBEEF strb 0xF same cycle, bready=1 -> bvalid 2 cycles later, bresp 0; read 0x0010 -> rdata 0xDEADBEEF, rresp 0, 1-cycle latency.
REQ-031 W 0x11223344 strb 0x5 three cycles before AW 0x0020 over word 0xFFFFFFFF -> awready stays high, wready low after W; word reads 0xFF22FF44.
REQ-032 bready held low 10 cycles -> bvalid/bresp stable; awready, wready stay 0; AR/R traffic proceeds unaffected.
REQ-033 AW 0x8000 (DEPTH_LOG2=8) -> bresp 2'b10, memory unchanged; read 0x8000 -> rdata 0, rresp 2'b10.
REQ-034 Read and write to 0x0040 (old 0x1, new 0x2) committing same edge -> rdata 0x1; next read returns 0x2.
REQ-035 rst pulsed while W held and AW pending, and while rvalid waiting -> bvalid/rvalid 0, readies 0 during reset, all 1 next cycle, target word unchanged.

Source files
------------

// File: rtl/axil_mem_target_pkg.sv
// axil_pkg: shared definitions for the AXI-lite memory target.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on bresp/rresp.
//   wstate_t / rstate_t     : write and read channel FSM states.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

endpackage

// File: rtl/axil_mem_target_if.sv
// axil_if: AXI-lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, write data, valids and response readies.
//   slave modport  : drives address/data readies, responses and read data.
interface axil_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/axil_mem_target_be_ram.sv
// be_ram: word-organised RAM with one byte-enabled write port and one
// registered read port. Contents are never reset.
//   clk     : clock
//   i_we    : write enable; i_waddr/i_wstrb/i_wdata select word, bytes, data
//   i_re    : read enable; o_rdata holds mem[i_raddr] from the previous edge
// A read and write to the same word on one edge returns the old contents.
module be_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/axil_mem_target.sv
// axil_mem_target: AXI-lite slave memory of 2^DEPTH_LOG2 words.
//   clk    : single clock, rising edge
//   rst    : synchronous active-high reset (control only; memory keeps data)
//   s_axil : AXI-lite slave port (axil_if.slave); awprot/arprot ignored
// Write and read channels run as two independent FSMs. Addresses with bits
// set above the memory window answer SLVERR, never write, and read as zero.
module axil_mem_target
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2 = 8
) (
  input logic   clk,
  input logic   rst,
  axil_if.slave s_axil
);
  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_W   = ADDR_WIDTH - ADDR_LSB;

  // Word address (byte-offset bits dropped) lies inside the memory window.
  function automatic logic f_in_range(input logic [WORD_W-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  wstate_t               r_wstate;
  logic                  r_aw_held, r_w_held;
  logic                  r_awready, r_wready;
  logic [WORD_W-1:0]     r_awword;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  rstate_t               r_rstate;
  logic                  r_arready, r_rvalid, r_rok;
  logic [1:0]            r_rresp;

  logic                  w_aw_take, w_w_take, w_ar_take, w_we, w_re;
  logic [WORD_W-1:0]     w_arword;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_aw_take = r_awready && s_axil.awvalid;
  assign w_w_take  = r_wready  && s_axil.wvalid;
  assign w_ar_take = r_arready && s_axil.arvalid;
  assign w_arword  = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];

  // Reset gates the RAM strobes so an in-flight commit is dropped.
  assign w_we = !rst && (r_wstate == W_IDLE) && r_aw_held && r_w_held
                && f_in_range(r_awword);
  assign w_re = !rst && w_ar_take;

  // Write channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awword  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_take) begin
            r_awword  <= s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
            r_aw_held <= 1'b1;
          end
          if (w_w_take) begin
            r_wdata  <= s_axil.wdata;
            r_wstrb  <= s_axil.wstrb;
            r_w_held <= 1'b1;
          end
          if (r_aw_held && r_w_held) begin
            r_bvalid  <= 1'b1;
            r_bresp   <= f_in_range(r_awword) ? RESP_OKAY : RESP_SLVERR;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            // Ready drops on the accepting edge; also rises after reset.
            r_awready <= !(r_aw_held || w_aw_take);
            r_wready  <= !(r_w_held  || w_w_take);
          end
        end
        W_RESP: begin
          if (s_axil.bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rok     <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_take) begin
            r_rvalid  <= 1'b1;
            r_rresp   <= f_in_range(w_arword) ? RESP_OKAY : RESP_SLVERR;
            r_rok     <= f_in_range(w_arword);
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axil.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  be_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_awword[DEPTH_LOG2-1:0]),
    .i_wstrb (r_wstrb),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_raddr (w_arword[DEPTH_LOG2-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign s_axil.awready = r_awready;
  assign s_axil.wready  = r_wready;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;
  assign s_axil.arready = r_arready;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rresp   = r_rresp;
  // The RAM output is not reset; masking gives zero after reset and on SLVERR.
  assign s_axil.rdata   = r_rok ? w_ram_rdata : '0;
endmodule

// File: tb/tb_axil_mem_target.sv
// Directed testbench for axil_mem_target.
module tb_axil_mem_target;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  axil_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4)) bus ();

  axil_mem_target #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .STRB_WIDTH (4),
    .DEPTH_LOG2 (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_hs, w_hs, done;
    resp = 2'bxx;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    for (int i = 0; i < 20 && (bus.awvalid || bus.wvalid); i++) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid  = 1'b0;
    end
    n_vec++;
    if (bus.awvalid || bus.wvalid) begin
      n_err++;
      $display("FAIL wr_accept addr=%h: awvalid=%0b wvalid=%0b still pending, required accepted", addr, bus.awvalid, bus.wvalid);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.bvalid) begin resp = bus.bresp; done = 1'b1; end
      tick();
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL wr_bvalid addr=%h: bvalid=0 after 20 cycles, required 1", addr);
    end
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    logic done;
    data = 'x; resp = 2'bxx;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.arready) done = 1'b1;
      tick();
    end
    bus.arvalid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; done = 1'b1; end
      tick();
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL rd_rvalid addr=%h: rvalid=0 after 20 cycles, required 1", addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL rst_awready got %b want 0", bus.awready); end
    n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL rst_wready got %b want 0", bus.wready); end
    n_vec++; if (bus.arready !== 1'b0) begin n_err++; $display("FAIL rst_arready got %b want 0", bus.arready); end
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL rst_bvalid got %b want 0", bus.bvalid); end
    n_vec++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b want 0", bus.rvalid); end
    n_vec++; if (bus.bresp !== 2'b00) begin n_err++; $display("FAIL rst_bresp got %b want 00", bus.bresp); end
    n_vec++; if (bus.rresp !== 2'b00) begin n_err++; $display("FAIL rst_rresp got %b want 00", bus.rresp); end
    n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL post_rst_awready got %b want 1", bus.awready); end
    n_vec++; if (bus.wready !== 1'b1) begin n_err++; $display("FAIL post_rst_wready got %b want 1", bus.wready); end
    n_vec++; if (bus.arready !== 1'b1) begin n_err++; $display("FAIL post_rst_arready got %b want 1", bus.arready); end
  endtask

  task automatic test_basic;
    bus.awaddr = 16'h0010; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n_vec++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL basic_awready_low got %b want 0", bus.awready); end
    n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL basic_wready_low got %b want 0", bus.wready); end
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL basic_bvalid_early got %b want 0", bus.bvalid); end
    tick();
    n_vec++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL basic_bvalid got %b want 1", bus.bvalid); end
    n_vec++; if (bus.bresp !== 2'b00) begin n_err++; $display("FAIL basic_bresp got %b want 00", bus.bresp); end
    tick();
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL basic_bvalid_fall got %b want 0", bus.bvalid); end
    n_vec++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL basic_awready_back got %b want 1", bus.awready); end
    bus.araddr = 16'h0010; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    n_vec++; if (bus.rvalid !== 1'b1) begin n_err++; $display("FAIL basic_rvalid got %b want 1", bus.rvalid); end
    n_vec++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rdata got %h want deadbeef", bus.rdata); end
    n_vec++; if (bus.rresp !== 2'b00) begin n_err++; $display("FAIL basic_rresp got %b want 00", bus.rresp); end
    n_vec++; if (bus.arready !== 1'b0) begin n_err++; $display("FAIL basic_arready_low got %b want 0", bus.arready); end
    tick();
    n_vec++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL basic_rvalid_fall got %b want 0", bus.rvalid); end
    n_vec++; if (bus.arready !== 1'b1) begin n_err++; $display("FAIL basic_arready_back got %b want 1", bus.arready); end
  endtask

  task automatic test_strobe;
    logic [1:0]  resp;
    logic [31:0] data;
    do_write(16'h0020, 32'hFFFFFFFF, 4'hF, resp);
    bus.wdata = 32'h11223344; bus.wstrb = 4'h5; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL strb_wready_low got %b want 0", bus.wready); end
    n_vec++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL strb_awready_high got %b want 1", bus.awready); end
    tick(); tick();
    n_vec++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL strb_awready_hold got %b want 1", bus.awready); end
    n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL strb_wready_hold got %b want 0", bus.wready); end
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL strb_bvalid_early got %b want 0", bus.bvalid); end
    bus.awaddr = 16'h0020; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    n_vec++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL strb_awready_low got %b want 0", bus.awready); end
    tick();
    n_vec++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL strb_bvalid got %b want 1", bus.bvalid); end
    tick();
    do_read(16'h0020, data, resp);
    n_vec++; if (data !== 32'hFF22FF44) begin n_err++; $display("FAIL strb_rdata got %h want ff22ff44", data); end
    do_write(16'h0020, 32'h00000000, 4'h0, resp);
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL strb0_bresp got %b want 00", resp); end
    do_read(16'h0020, data, resp);
    n_vec++; if (data !== 32'hFF22FF44) begin n_err++; $display("FAIL strb0_rdata got %h want ff22ff44", data); end
  endtask

  task automatic test_backpressure;
    logic [1:0]  resp;
    logic [31:0] data;
    bus.bready = 1'b0;
    bus.awaddr = 16'h0030; bus.awvalid = 1'b1;
    bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    do_read(16'h0010, data, resp);
    n_vec++; if (data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bp_read_rdata got %h want deadbeef", data); end
    n_vec++; if (resp !== 2'b00) begin n_err++; $display("FAIL bp_read_rresp got %b want 00", resp); end
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL bp_bvalid[%0d] got %b want 1", i, bus.bvalid); end
      n_vec++; if (bus.bresp !== 2'b00) begin n_err++; $display("FAIL bp_bresp[%0d] got %b want 00", i, bus.bresp); end
      n_vec++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL bp_awready[%0d] got %b want 0", i, bus.awready); end
      n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL bp_wready[%0d] got %b want 0", i, bus.wready); end
      tick();
    end
    bus.bready = 1'b1;
    tick();
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL bp_bvalid_fall got %b want 0", bus.bvalid); end
    do_read(16'h0030, data, resp);
    n_vec++; if (data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bp_rdata got %h want a5a5a5a5", data); end
  endtask

  task automatic test_range;
    logic [1:0]  resp;
    logic [31:0] data;
    do_write(16'h0000, 32'hCAFEF00D, 4'hF, resp);
    do_write(16'h8000, 32'h12345678, 4'hF, resp);
    n_vec++; if (resp !== 2'b10) begin n_err++; $display("FAIL oor_bresp got %b want 10", resp); end
    do_read(16'h0000, data, resp);
    n_vec++; if (data !== 32'hCAFEF00D) begin n_err++; $display("FAIL oor_alias_word got %h want cafef00d", data); end
    do_read(16'h8000, data, resp);
    n_vec++; if (data !== 32'h0) begin n_err++; $display("FAIL oor_rdata got %h want 0", data); end
    n_vec++; if (resp !== 2'b10) begin n_err++; $display("FAIL oor_rresp got %b want 10", resp); end
  endtask

  task automatic test_rbw;
    logic [1:0]  resp;
    logic [31:0] data;
    do_write(16'h0040, 32'h00000001, 4'hF, resp);
    bus.awaddr = 16'h0040; bus.awvalid = 1'b1;
    bus.wdata = 32'h00000002; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 16'h0040; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    n_vec++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL rbw_bvalid got %b want 1", bus.bvalid); end
    n_vec++; if (bus.rvalid !== 1'b1) begin n_err++; $display("FAIL rbw_rvalid got %b want 1", bus.rvalid); end
    n_vec++; if (bus.rdata !== 32'h1) begin n_err++; $display("FAIL rbw_old_rdata got %h want 1", bus.rdata); end
    tick();
    do_read(16'h0040, data, resp);
    n_vec++; if (data !== 32'h2) begin n_err++; $display("FAIL rbw_new_rdata got %h want 2", data); end
  endtask

  task automatic test_reset_mid;
    logic [1:0]  resp;
    logic [31:0] data;
    do_write(16'h0050, 32'h55AA55AA, 4'hF, resp);
    bus.rready = 1'b0;
    bus.wdata = 32'h0BADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 16'h0010; bus.arvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL rm_wready_held got %b want 0", bus.wready); end
    n_vec++; if (bus.rvalid !== 1'b1) begin n_err++; $display("FAIL rm_rvalid_wait got %b want 1", bus.rvalid); end
    bus.awaddr = 16'h0050; bus.awvalid = 1'b1;
    rst = 1'b1;
    tick();
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL rm_bvalid got %b want 0", bus.bvalid); end
    n_vec++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL rm_rvalid got %b want 0", bus.rvalid); end
    n_vec++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL rm_awready got %b want 0", bus.awready); end
    n_vec++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL rm_wready got %b want 0", bus.wready); end
    n_vec++; if (bus.arready !== 1'b0) begin n_err++; $display("FAIL rm_arready got %b want 0", bus.arready); end
    n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rm_rdata got %h want 0", bus.rdata); end
    bus.awvalid = 1'b0;
    rst = 1'b0; bus.rready = 1'b1;
    tick();
    n_vec++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL rm_post_awready got %b want 1", bus.awready); end
    n_vec++; if (bus.wready !== 1'b1) begin n_err++; $display("FAIL rm_post_wready got %b want 1", bus.wready); end
    n_vec++; if (bus.arready !== 1'b1) begin n_err++; $display("FAIL rm_post_arready got %b want 1", bus.arready); end
    tick(); tick();
    n_vec++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL rm_no_late_bvalid got %b want 0", bus.bvalid); end
    do_read(16'h0050, data, resp);
    n_vec++; if (data !== 32'h55AA55AA) begin n_err++; $display("FAIL rm_word_kept got %h want 55aa55aa", data); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    test_reset();
    test_basic();
    test_strobe();
    test_backpressure();
    test_range();
    test_rbw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
